// File: rtl/port_tx_pkg.sv
// port_tx shared package: FSM states and header layout.
// Used by port_tx (optional build macro: PORT_TX_AF_BLOCK_EN).
package port_tx_pkg;

  localparam int DEST_W = 4;
  localparam int PRIO_W = 3;

  localparam int HDR_DEST_LSB = 0;
  localparam int HDR_PRIO_LSB = 4;
  localparam int HDR_LEN_LSB  = 7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SOP,
    ST_HDR,
    ST_DATA,
    ST_LAST,
    ST_EOP
  } state_t;

endpackage

// File: rtl/port_tx.sv
// port_tx: frames upstream packets into switch write beats.
// Define PORT_TX_AF_BLOCK_EN to also hold starts on almost_full.
module port_tx
  import port_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 256,
  parameter int NUM_PRIO   = 8,
  parameter int LEN_W      = 9
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_vld,
  output logic                  s_rdy,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_last,
  input  logic [3:0]            s_dest,
  input  logic [2:0]            s_prio,
  input  logic [LEN_W-1:0]      s_len,
  output logic                  wr_sop,
  output logic                  wr_eop,
  output logic                  wr_vld,
  output logic [DATA_WIDTH-1:0] wr_data,
  input  logic [NUM_PRIO-1:0]   full,
  input  logic [NUM_PRIO-1:0]   almost_full,
  output logic                  len_err,
  output logic [31:0]           pkt_cnt
);

  localparam logic [LEN_W-1:0] CNT_MAX = '1;

  state_t r_state;
  state_t w_next;

  logic [DEST_W-1:0]     r_dest;
  logic [PRIO_W-1:0]     r_prio;
  logic [LEN_W-1:0]      r_len;
  logic [LEN_W-1:0]      r_cnt;
  logic                  r_err;

  logic                  r_wr_sop;
  logic                  r_wr_eop;
  logic                  r_wr_vld;
  logic [DATA_WIDTH-1:0] r_wr_data;
  logic                  r_len_err;
  logic [31:0]           r_pkt_cnt;

  logic                  w_blk;
  logic                  w_start;
  logic                  w_acc;
  logic                  w_cnt_max;
  logic [LEN_W-1:0]      w_cnt_inc;
  logic                  w_bad_len;
  logic [DATA_WIDTH-1:0] w_hdr;

`ifdef PORT_TX_AF_BLOCK_EN
  assign w_blk = full[s_prio] | almost_full[s_prio];
`else
  logic w_unused_af;
  assign w_unused_af = ^almost_full;
  assign w_blk = full[s_prio];
`endif

  assign w_start   = (r_state == ST_IDLE) && s_vld && !w_blk;
  assign w_acc     = s_vld && s_rdy;
  assign w_cnt_max = (r_cnt == CNT_MAX);
  assign w_cnt_inc = r_cnt + LEN_W'(1);
  // a beat past saturation is an overrun even if len is the max value
  assign w_bad_len = w_cnt_max || (w_cnt_inc != r_len);

  // header word built from the fields latched at start
  always_comb begin
    w_hdr = '0;
    w_hdr[HDR_DEST_LSB +: DEST_W] = r_dest;
    w_hdr[HDR_PRIO_LSB +: PRIO_W] = r_prio;
    w_hdr[HDR_LEN_LSB  +: LEN_W]  = r_len;
  end

  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // next state and upstream ready; the header cycle already
  // accepts the first beat so payload follows header gap-free
  always_comb begin
    w_next = r_state;
    s_rdy  = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_start) w_next = ST_SOP;
      end
      ST_SOP: begin
        w_next = ST_HDR;
      end
      ST_HDR: begin
        s_rdy  = 1'b1;
        w_next = (s_vld && s_last) ? ST_LAST : ST_DATA;
      end
      ST_DATA: begin
        s_rdy = 1'b1;
        if (s_vld && s_last) w_next = ST_LAST;
      end
      ST_LAST: begin
        w_next = ST_EOP;
      end
      ST_EOP: begin
        w_next = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // per-packet context: latched header fields and beat counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dest <= '0;
      r_prio <= '0;
      r_len  <= '0;
      r_cnt  <= '0;
      r_err  <= 1'b0;
    end else begin
      if (w_start) begin
        r_dest <= s_dest;
        r_prio <= s_prio;
        r_len  <= s_len;
        r_cnt  <= '0;
        r_err  <= 1'b0;
      end
      if (w_acc) begin
        r_cnt <= w_cnt_max ? r_cnt : w_cnt_inc;
        if (s_last) r_err <= w_bad_len;
      end
    end
  end

  // registered write framing, data and statistics
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_sop  <= 1'b0;
      r_wr_eop  <= 1'b0;
      r_wr_vld  <= 1'b0;
      r_wr_data <= '0;
      r_len_err <= 1'b0;
      r_pkt_cnt <= '0;
    end else begin
      r_wr_sop  <= w_start;
      r_wr_eop  <= (r_state == ST_LAST);
      r_len_err <= (r_state == ST_LAST) && r_err;
      r_wr_vld  <= 1'b0;
      r_wr_data <= '0;
      if (r_state == ST_SOP) begin
        r_wr_vld  <= 1'b1;
        r_wr_data <= w_hdr;
      end else if (w_acc) begin
        r_wr_vld  <= 1'b1;
        r_wr_data <= s_data;
      end
      if (r_state == ST_LAST) begin
        r_pkt_cnt <= r_pkt_cnt + 32'd1;
      end
    end
  end

  assign wr_sop  = r_wr_sop;
  assign wr_eop  = r_wr_eop;
  assign wr_vld  = r_wr_vld;
  assign wr_data = r_wr_data;
  assign len_err = r_len_err;
  assign pkt_cnt = r_pkt_cnt;

endmodule

// File: doc/port_tx.md
PORT_TX -- requirements
Module: port_tx

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 256, write-data width in bits.
REQ-002 SHALL have parameter NUM_PRIO, default 8, number of priority queues per port.
REQ-003 SHALL have parameter LEN_W, default 9, width of the payload-length field in beats.
REQ-004 SHALL have port clk  input  1  single clock; all logic is on the rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port s_vld  input  1  upstream beat valid.
REQ-007 SHALL have port s_rdy  output  1  upstream beat ready.
REQ-008 SHALL have port s_data  input  DATA_WIDTH  upstream payload beat.
REQ-009 SHALL have port s_last  input  1  final payload beat of the packet.
REQ-010 SHALL have port s_dest  input  4  destination port; valid with the first beat.
REQ-011 SHALL have port s_prio  input  3  priority; valid with the first beat.
REQ-012 SHALL have port s_len  input  LEN_W  declared payload beats (1..2^LEN_W-1); valid with the first beat.
REQ-013 SHALL have ports wr_sop, wr_eop and wr_vld, each output 1, the switch write framing.
REQ-014 SHALL have port wr_data  output  DATA_WIDTH  switch write data.
REQ-015 SHALL have ports full and almost_full, each input NUM_PRIO, per-priority switch queue status.
REQ-016 SHALL have port len_err  output  1  one-cycle pulse on a length mismatch.
REQ-017 SHALL have port pkt_cnt  output  32  count of packets completed (wr_eop issued).

Function
REQ-018 SHALL implement the states IDLE, SOP, HDR, DATA, LAST and EOP.
REQ-019 IDLE: when s_vld=1 and the start is not blocked (REQ-031/032), SHALL latch s_dest, s_prio and s_len and go to SOP; s_rdy=0.
REQ-020 SOP: SHALL drive wr_sop=1, wr_vld=0 for exactly one cycle, then go to HDR.
REQ-021 HDR: SHALL drive wr_vld=1 with wr_data = header (bits[3:0]=dest, [6:4]=prio, [6+LEN_W:7]=len, rest 0) for one cycle, then go to DATA.
REQ-022 DATA: SHALL drive s_rdy=1; each s_vld&s_rdy beat SHALL appear on wr_data with wr_vld=1 on the next cycle (1-cycle latency).
REQ-023 DATA: a cycle with no accepted beat SHALL give wr_vld=0 on the next cycle; such bubbles are legal and do not end the packet.
REQ-024 Accepting a beat with s_last=1 SHALL move to LAST with s_rdy=0; LAST outputs the last beat with wr_vld=1.
REQ-025 EOP: SHALL drive wr_eop=1, wr_vld=0 for one cycle, increment pkt_cnt (wrapping at 2^32), then go to IDLE.
REQ-026 SHALL hold a minimum of one IDLE cycle between wr_eop and the next wr_sop.
REQ-027 SHALL count accepted beats in a LEN_W-bit counter; if the counter at s_last is not equal to the latched len, or the counter saturates without s_last, SHALL pulse len_err in the EOP cycle.
REQ-028 The packet SHALL always end at s_last; a header that carries the declared length is not rewritten.
REQ-029 wr_sop, wr_eop and wr_vld SHALL be mutually exclusive in every cycle.
REQ-030 full and almost_full SHALL be evaluated only in IDLE; changes mid-packet SHALL NOT stall or abort the packet.

Configuration
REQ-031 Without PORT_TX_AF_BLOCK_EN, a start SHALL be blocked only when full[s_prio]=1.
REQ-032 With PORT_TX_AF_BLOCK_EN defined, a start SHALL be blocked when full[s_prio]=1 or almost_full[s_prio]=1.

Reset
REQ-033 rst=1 SHALL force state IDLE, s_rdy=0, wr_sop=wr_eop=wr_vld=0, wr_data=0, len_err=0, pkt_cnt=0 and the beat counter to 0 on the next edge.
REQ-034 A reset mid-packet SHALL abandon the packet with no wr_eop; the first cycle after rst deasserts is IDLE.

Structure
REQ-035 A shared package SHALL hold the state enumeration, the header field offsets, and DEST_W=4 and PRIO_W=3.
REQ-036 No sub-module is needed; the FSM, counters and output registers SHALL sit in port_tx.

Verification
REQ-037 3-beat packet (dest=5, prio=2, len=3), all full=0 -> sop at t; header at t+1 with bits[6:0]=0x25 and len=3; data at t+2..t+4; eop at t+5; pkt_cnt=1; len_err=0.
REQ-038 full[2]=1 with a pending prio-2 packet for 10 cycles, then full[2]=0 -> no wr_sop while full=1; wr_sop one cycle after full clears.
REQ-039 almost_full[2]=1, full=0 -> packet starts without the macro; blocked with PORT_TX_AF_BLOCK_EN.
REQ-040 len=4 but s_last on beat 2 -> 2 data beats, then wr_eop with len_err=1 in the same cycle.
REQ-041 s_vld low for 2 cycles mid-packet, then rst asserted in DATA -> a 2-cycle wr_vld gap; after reset all outputs are 0, pkt_cnt=0 and no wr_eop is emitted.
